// File: rtl/clarke_inverse_axis_if.sv
`default_nettype none
// ============================================================================
//  Module   : clarke_inverse_axis_if
//  Brief    : AXI-stream style bus (tdata/tvalid/tready) for the inverse Clarke stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface clarke_inverse_axis_if #(
    parameter int WIDTH = 64
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/clarke_inverse_axis.sv
`default_nettype none
// ============================================================================
//  Module   : clarke_inverse_axis
//  Brief    : Handshaked inverse Clarke (alpha/beta -> a/b/c), 3-cycle latency.
//             Define CLARKE_INV_SAT_EN to clip Vb/Vc and count saturated beats.
//  Revision : 1.0 - initial release
// ============================================================================
module clarke_inverse_axis #(
    parameter int DATA_W = 16,
    parameter int COEF   = 28378,
    parameter int COEF_W = 16,
    parameter int FRAC   = 15,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    clarke_inverse_axis_if.slave  s_axis,
    clarke_inverse_axis_if.master m_axis,
    input  logic                 sat_clr,
    output logic [CNT_W-1:0]     sat_cnt
);
    localparam int c_P_W = DATA_W + COEF_W + 1;
    localparam int c_R_W = DATA_W + 2;
    localparam logic signed [COEF_W:0]     c_COEF    = {1'b0, COEF_W'(COEF)};
    localparam logic signed [c_P_W-1:0]    c_HALF    = c_P_W'(1) << (FRAC - 1);
    localparam logic signed [DATA_W-1:0]   c_MAX     = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0]   c_MIN     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [c_R_W-1:0]    c_MAX_EXT = c_R_W'(c_MAX);
    localparam logic signed [c_R_W-1:0]    c_MIN_EXT = c_R_W'(c_MIN);

    logic                     w_adv;
    logic                     w_s_ready;

    logic                     r_s1_valid;
    logic signed [DATA_W-1:0] r_s1_alpha;
    logic signed [DATA_W-1:0] r_s1_beta;
    logic        [DATA_W-1:0] r_s1_theta;

    logic                     r_s2_valid;
    logic signed [c_P_W-1:0]  r_s2_p;
    logic signed [DATA_W-1:0] r_s2_alpha;
    logic        [DATA_W-1:0] r_s2_theta;

    logic                     r_s3_valid;
    logic signed [c_R_W-1:0]  r_s3_s;
    logic signed [DATA_W-1:0] r_s3_h;
    logic signed [DATA_W-1:0] r_s3_alpha;
    logic        [DATA_W-1:0] r_s3_theta;

    logic                     r_out_valid;
    logic [4*DATA_W-1:0]      r_out_data;
    logic [CNT_W-1:0]         r_sat_cnt;

    logic signed [c_P_W-1:0]  w_prod;
    logic signed [c_P_W-1:0]  w_p_rnd;
    logic signed [c_P_W-1:0]  w_s_full;
    logic signed [c_R_W-1:0]  w_h_ext;
    logic signed [c_R_W-1:0]  w_vb;
    logic signed [c_R_W-1:0]  w_vc;
    logic        [DATA_W-1:0] w_vb_out;
    logic        [DATA_W-1:0] w_vc_out;
    logic                     w_sat_evt;
    logic                     w_unused_bits;

    // Whole pipeline advances in lockstep; ready is combinational from the output side.
    assign w_adv         = !r_out_valid | m_axis.tready;
    assign w_s_ready     = w_adv & !rst;
    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = r_out_valid;
    assign m_axis.tdata  = r_out_data;
    assign sat_cnt       = r_sat_cnt;

    assign w_prod   = r_s1_beta * c_COEF;
    assign w_p_rnd  = r_s2_p + c_HALF;
    assign w_s_full = w_p_rnd >>> FRAC;
    assign w_h_ext  = c_R_W'(r_s3_h);
    assign w_vb     = r_s3_s - w_h_ext;
    assign w_vc     = -r_s3_s - w_h_ext;

`ifdef CLARKE_INV_SAT_EN
    logic w_ovf_b;
    logic w_ovf_c;
    assign w_ovf_b   = (w_vb > c_MAX_EXT) || (w_vb < c_MIN_EXT);
    assign w_ovf_c   = (w_vc > c_MAX_EXT) || (w_vc < c_MIN_EXT);
    assign w_vb_out  = w_ovf_b ? (w_vb[c_R_W-1] ? c_MIN : c_MAX) : w_vb[DATA_W-1:0];
    assign w_vc_out  = w_ovf_c ? (w_vc[c_R_W-1] ? c_MIN : c_MAX) : w_vc[DATA_W-1:0];
    assign w_sat_evt = w_adv & r_s3_valid & (w_ovf_b | w_ovf_c);
    assign w_unused_bits = ^{s_axis.tdata[4*DATA_W-1:3*DATA_W], w_s_full[c_P_W-1:c_R_W]};
`else
    assign w_vb_out  = w_vb[DATA_W-1:0];
    assign w_vc_out  = w_vc[DATA_W-1:0];
    assign w_sat_evt = 1'b0;
    assign w_unused_bits = ^{s_axis.tdata[4*DATA_W-1:3*DATA_W], w_s_full[c_P_W-1:c_R_W],
                             w_vb[c_R_W-1:DATA_W], w_vc[c_R_W-1:DATA_W]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_alpha  <= '0;
            r_s1_beta   <= '0;
            r_s1_theta  <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_p      <= '0;
            r_s2_alpha  <= '0;
            r_s2_theta  <= '0;
            r_s3_valid  <= 1'b0;
            r_s3_s      <= '0;
            r_s3_h      <= '0;
            r_s3_alpha  <= '0;
            r_s3_theta  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= s_axis.tvalid & w_s_ready;
            r_s1_alpha  <= s_axis.tdata[DATA_W-1:0];
            r_s1_beta   <= s_axis.tdata[2*DATA_W-1:DATA_W];
            r_s1_theta  <= s_axis.tdata[3*DATA_W-1:2*DATA_W];
            r_s2_valid  <= r_s1_valid;
            r_s2_p      <= w_prod;
            r_s2_alpha  <= r_s1_alpha;
            r_s2_theta  <= r_s1_theta;
            r_s3_valid  <= r_s2_valid;
            r_s3_s      <= w_s_full[c_R_W-1:0];
            r_s3_h      <= r_s2_alpha >>> 1;
            r_s3_alpha  <= r_s2_alpha;
            r_s3_theta  <= r_s2_theta;
            r_out_valid <= r_s3_valid;
            r_out_data  <= {r_s3_theta, w_vc_out, w_vb_out, r_s3_alpha};
        end
    end

    // Clear wins over a same-edge increment; the count saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_sat_evt && (r_sat_cnt != {CNT_W{1'b1}})) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_clarke_inverse_axis.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clarke_inverse_axis
//  Brief    : Directed self-checking bench for clarke_inverse_axis (CNT_W=4 for sticky test).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clarke_inverse_axis;
    localparam int W     = 16;
    localparam int CNT_W = 4;
`ifdef CLARKE_INV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sat_clr = 1'b0;
    logic [CNT_W-1:0] sat_cnt;
    int               checks = 0;
    int               errors = 0;

    clarke_inverse_axis_if #(.WIDTH(4*W)) s_if ();
    clarke_inverse_axis_if #(.WIDTH(4*W)) m_if ();

    clarke_inverse_axis #(
        .DATA_W(W), .COEF(28378), .COEF_W(16), .FRAC(15), .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_axis  (s_if),
        .m_axis  (m_if),
        .sat_clr (sat_clr),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pack(input int th, input int vc, input int vb, input int va);
        logic [31:0] t, c, b, a;
        t = th; c = vc; b = vb; a = va;
        return {t[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic send_and_get(input int a, input int b, input int th,
                                output logic [63:0] got, output int lat);
        logic [31:0] ta, tb, tt;
        ta = a; tb = b; tt = th;
        @(posedge clk); #1;
        s_if.tdata  = {16'h0, tt[15:0], tb[15:0], ta[15:0]};
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        lat = 0;
        while (!m_if.tvalid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        got = m_if.tdata;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; sat_clr = 1'b1;
        @(posedge clk); #1; sat_clr = 1'b0;
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_if.tvalid); end
        checks++; if (m_if.tdata !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", m_if.tdata); end
        checks++; if (sat_cnt !== '0) begin errors++; $display("FAIL reset_satcnt got=%0d exp=0", sat_cnt); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b exp=0", s_if.tready); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int a[6]  = '{1000, 0, -1, 2000, 0, 0};
        int b[6]  = '{0, 1000, 0, -1000, 1, -1};
        int th[6] = '{'h1234, 1, 2, 3, 4, 5};
        int vb[6] = '{-500, 866, 1, -1866, 1, -1};
        int vc[6] = '{-500, -866, 1, -134, -1, 1};
        logic [63:0] got, exp;
        int lat;
        for (int i = 0; i < 6; i++) begin
            send_and_get(a[i], b[i], th[i], got, lat);
            exp = pack(th[i], vc[i], vb[i], a[i]);
            checks++; if (got !== exp) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got, exp); end
            checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency[%0d] got=%0d exp=3", i, lat); end
        end
    endtask

    task automatic test_saturation();
        int a[3]  = '{-32768, 32767, -32768};
        int b[3]  = '{32767, -32768, -32768};
        int vb[3] = '{SAT ? 32767 : -20775, SAT ? -32768 : 20775, -11994};
        int vc[3] = '{-11993, 11995, SAT ? 32767 : -20774};
        logic [63:0] got, exp;
        int lat;
        pulse_clr();
        for (int i = 0; i < 3; i++) begin
            send_and_get(a[i], b[i], 7 + i, got, lat);
            exp = pack(7 + i, vc[i], vb[i], a[i]);
            checks++; if (got !== exp) begin errors++; $display("FAIL sat_data[%0d] got=%h exp=%h", i, got, exp); end
            checks++; if (sat_cnt !== CNT_W'(SAT ? i + 1 : 0)) begin
                errors++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, sat_cnt, SAT ? i + 1 : 0); end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, recv = 0;
        logic [63:0] prev, exp;
        logic [31:0] ts, ta;
        prev = '0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            @(posedge clk); #1;
            m_if.tready = !(cyc >= 4 && cyc <= 9);
            s_if.tvalid = (sent < 8);
            ts = sent; ta = 100 * (sent + 1);
            s_if.tdata  = {16'h0, ts[15:0], 16'h0, ta[15:0]};
            #1;
            if (cyc >= 4 && cyc <= 9) begin
                checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL bp_tready cyc=%0d got=%b exp=0", cyc, s_if.tready); end
                if (cyc > 4) begin
                    checks++; if (m_if.tdata !== prev) begin errors++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", cyc, m_if.tdata, prev); end
                end
            end
            prev = m_if.tdata;
            if (m_if.tvalid && m_if.tready) begin
                exp = pack(recv, -50 * (recv + 1), -50 * (recv + 1), 100 * (recv + 1));
                checks++; if (m_if.tdata !== exp) begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", recv, m_if.tdata, exp); end
                recv++;
            end
            if (s_if.tvalid && s_if.tready) sent++;
        end
        s_if.tvalid = 1'b0; m_if.tready = 1'b1;
        checks++; if (recv !== 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", recv); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b exp=0", m_if.tvalid); end
    endtask

    task automatic test_reset_midstream();
        logic [63:0] got, exp;
        int lat, stale;
        pulse_clr();
        m_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            s_if.tvalid = 1'b1;
            s_if.tdata  = (i == 0) ? {16'h0, 16'h0, 16'h7FFF, 16'h8000} : {16'h0, 16'h0, 16'h0, 16'd64};
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL rstm_pre_valid got=%b exp=1", m_if.tvalid); end
        checks++; if (sat_cnt !== CNT_W'(SAT ? 1 : 0)) begin errors++; $display("FAIL rstm_pre_cnt got=%0d exp=%0d", sat_cnt, SAT ? 1 : 0); end
        #1 rst = 1'b1;
        #1;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rstm_valid got=%b exp=0", m_if.tvalid); end
        checks++; if (sat_cnt !== '0) begin errors++; $display("FAIL rstm_cnt got=%0d exp=0", sat_cnt); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rstm_tready got=%b exp=0", s_if.tready); end
        @(posedge clk); #1;
        rst = 1'b0; m_if.tready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (m_if.tvalid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rstm_stale got=%0d exp=0", stale); end
        send_and_get(300, 0, 'h55, got, lat);
        exp = pack('h55, -150, -150, 300);
        checks++; if (got !== exp) begin errors++; $display("FAIL rstm_fresh got=%h exp=%h", got, exp); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rstm_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_sat_clr();
        logic [63:0] got;
        int lat;
        pulse_clr();
        send_and_get(-32768, 32767, 1, got, lat);
        checks++; if (sat_cnt !== CNT_W'(SAT ? 1 : 0)) begin errors++; $display("FAIL clr_pre got=%0d exp=%0d", sat_cnt, SAT ? 1 : 0); end
        @(posedge clk); #1;
        s_if.tdata = {16'h0, 16'h0, 16'h7FFF, 16'h8000}; s_if.tvalid = 1'b1;
        @(posedge clk); #1; s_if.tvalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; sat_clr = 1'b1;
        @(posedge clk); #1; sat_clr = 1'b0;
        checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL clr_valid got=%b exp=1", m_if.tvalid); end
        checks++; if (sat_cnt !== '0) begin errors++; $display("FAIL clr_coincident got=%0d exp=0", sat_cnt); end
    endtask

    task automatic test_sat_sticky();
        pulse_clr();
        m_if.tready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            s_if.tvalid = 1'b1;
            s_if.tdata  = {16'h0, 16'h0, 16'h7FFF, 16'h8000};
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (sat_cnt !== CNT_W'(SAT ? 15 : 0)) begin errors++; $display("FAIL sticky got=%0d exp=%0d", sat_cnt, SAT ? 15 : 0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_reset_midstream();
        test_sat_clr();
        test_sat_sticky();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
